// File: rtl/serial_add_pkg.sv
// Shared state encoding and default operand width for the bit-serial adder controller.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Counter must be able to hold WIDTH-1 for every legal WIDTH, including 1.
  function automatic int cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Host request/response bus plus the one-bit adder hookup of the serial add controller.
// Host drives start/operands; the controller drives status, result and the adder bit lanes.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout_out;

  logic             add_a;
  logic             add_b;
  logic             add_cin;
  logic             add_sum;
  logic             add_cout;

  modport master (
    output start, op_a, op_b, cin_in,
    input  busy, done, result, cout_out
  );

  modport slave (
    input  start, op_a, op_b, cin_in, add_sum, add_cout,
    output busy, done, result, cout_out, add_a, add_b, add_cin
  );

  modport adder (
    input  add_a, add_b, add_cin,
    output add_sum, add_cout
  );

endinterface

// File: rtl/basic_one_bit_adder.sv
// Registered full adder: sum/carry of a+b+cin appear one rising edge after the inputs.
// No flow control; synchronous active-high reset clears both outputs.
module basic_one_bit_adder (
  input  logic clk,
  input  logic rst,
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  logic sum_q, sum_d;
  logic cout_q, cout_d;

  always_comb begin
    sum_d  = a_i ^ b_i ^ cin_i;
    cout_d = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 1'b0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add controller: streams operands LSB-first through an external registered adder.
// done pulses WIDTH+1 edges after the accepting edge; start is ignored while busy.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic             clk,
  input logic             rst,
  serial_add_ctrl_if.slave bus
);

  localparam int            CW   = cnt_bits(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cin_q, cin_d;
  logic             cout_q, cout_d;
  logic [WIDTH:0]   res_shift;

  // Widened shift keeps the MSB-side insert legal when WIDTH is 1.
  assign res_shift = {bus.add_sum, res_q} >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    res_d       = res_q;
    cout_d      = cout_q;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.add_a   = 1'b0;
    bus.add_b   = 1'b0;
    bus.add_cin = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        bus.done = (state_q == DONE);
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          cin_d   = bus.cin_in;
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        bus.busy    = 1'b1;
        bus.add_a   = a_q[0];
        bus.add_b   = b_q[0];
        bus.add_cin = (cnt_q == '0) ? cin_q : bus.add_cout;
        a_d         = a_q >> 1;
        b_d         = b_q >> 1;
        // The adder lags one cycle, so the first capture belongs to the edge ending k=1.
        if (cnt_q != '0) begin
          res_d = res_shift[WIDTH-1:0];
        end
        if (cnt_q == LAST) begin
          state_d = FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      FLUSH: begin
        bus.busy = 1'b1;
        res_d    = res_shift[WIDTH-1:0];
        cout_d   = bus.add_cout;
        state_d  = DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.result   = res_q;
  assign bus.cout_out = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1, each paired with its own adder.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) b8 ();
  serial_add_ctrl_if #(.WIDTH(1)) b1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  basic_one_bit_adder u_add8 (
    .clk(clk), .rst(rst), .a_i(b8.add_a), .b_i(b8.add_b), .cin_i(b8.add_cin),
    .sum_o(b8.add_sum), .cout_o(b8.add_cout)
  );
  basic_one_bit_adder u_add1 (
    .clk(clk), .rst(rst), .a_i(b1.add_a), .b_i(b1.add_b), .cin_i(b1.add_cin),
    .sum_o(b1.add_sum), .cout_o(b1.add_cout)
  );

  typedef struct {
    logic [8:0] sum;
    int         t;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (b8.done === 1'b1) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 1, 0);
      end else begin
        e = q8.pop_front();
        chk("w8_sum", {b8.cout_out, b8.result}, e.sum);
        chk("w8_done_cycle", cyc, e.t);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b1.done === 1'b1) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_done", 1, 0);
      end else begin
        e = q1.pop_front();
        chk("w1_sum", {b1.cout_out, b1.result}, e.sum);
        chk("w1_done_cycle", cyc, e.t);
      end
    end
  end

  // Called at a negedge; returns at the negedge inside RUN cycle 0.
  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
    b8.start  = 1'b1;
    b8.op_a   = a;
    b8.op_b   = b;
    b8.cin_in = c;
    if (push) q8.push_back('{sum: 9'(a) + 9'(b) + 9'(c), t: cyc + 10});
    @(negedge clk);
    b8.start = 1'b0;
  endtask

  // Walks RUN and FLUSH, checking the bit lanes; returns at the negedge inside DONE.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input int inj_k);
    int lo;
    for (int k = 0; k < 8; k++) begin
      lo = (int'(a) % (1 << k)) + (int'(b) % (1 << k)) + int'(c);
      chk("w8_busy_run", b8.busy, 1);
      chk("w8_add_a", b8.add_a, a[k]);
      chk("w8_add_b", b8.add_b, b[k]);
      chk("w8_add_cin", b8.add_cin, (lo >> k) & 1);
      if (k == inj_k) begin
        b8.start  = 1'b1;
        b8.op_a   = 8'($urandom);
        b8.op_b   = 8'($urandom);
        b8.cin_in = 1'($urandom);
      end
      @(negedge clk);
      b8.start = 1'b0;
    end
    chk("w8_busy_flush", b8.busy, 1);
    chk("w8_lanes_flush", {b8.add_a, b8.add_b, b8.add_cin}, 0);
    @(negedge clk);
    chk("w8_busy_done", b8.busy, 0);
    chk("w8_done_pulse", b8.done, 1);
  endtask

  task automatic idle8(input int n, input logic [8:0] exp);
    repeat (n) begin
      @(negedge clk);
      chk("w8_hold", {b8.cout_out, b8.result}, exp);
      chk("w8_idle_status", {b8.busy, b8.done}, 0);
      chk("w8_lanes_idle", {b8.add_a, b8.add_b, b8.add_cin}, 0);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, input int inj_k);
    launch8(a, b, c, 1'b1);
    run8(a, b, c, inj_k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [2:0] abc;

    b8.start = 1'b0; b8.op_a = '0; b8.op_b = '0; b8.cin_in = 1'b0;
    b1.start = 1'b0; b1.op_a = '0; b1.op_b = '0; b1.cin_in = 1'b0;

    // Reset has priority over a simultaneous start.
    repeat (2) @(negedge clk);
    b8.start = 1'b1; b8.op_a = 8'hAA; b8.op_b = 8'h55;
    @(negedge clk);
    b8.start = 1'b0;
    chk("rst_w8_outputs", {b8.busy, b8.done, b8.cout_out, b8.result}, 0);
    chk("rst_w8_lanes", {b8.add_a, b8.add_b, b8.add_cin}, 0);
    chk("rst_w1_outputs", {b1.busy, b1.done, b1.cout_out, b1.result}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_w8_idle", {b8.busy, b8.done}, 0);

    op8(8'h5A, 8'h3C, 1'b0, 99);
    idle8(2, 9'h096);
    op8(8'hFF, 8'h01, 1'b0, 99);
    idle8(1, 9'h100);

    // Back-to-back: start accepted during DONE.
    op8(8'hFF, 8'hFF, 1'b1, 99);
    op8(8'h01, 8'h01, 1'b0, 99);
    idle8(1, 9'h002);

    // A start during RUN cycle 3 must not disturb the operation.
    op8(8'h33, 8'h44, 1'b1, 3);
    idle8(1, 9'h078);

    // Abort in RUN cycle 4: no done, everything cleared.
    launch8(8'hC3, 8'h5E, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {b8.busy, b8.done, b8.cout_out, b8.result}, 0);
    chk("abort_lanes", {b8.add_a, b8.add_b, b8.add_cin}, 0);
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", b8.done, 0);
    end
    op8(8'h10, 8'h20, 1'b0, 99);
    idle8(1, 9'h030);

    // Random operations with mixed gaps, back-to-back starts and ignored starts.
    repeat (40) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      op8(ra, rb, rc, int'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) != 0) idle8(int'($urandom_range(1, 3)), 9'(ra) + 9'(rb) + 9'(rc));
    end
    idle8(1, 9'(ra) + 9'(rb) + 9'(rc));

    // WIDTH=1: every (a,b,cin) combination.
    for (int v = 0; v < 8; v++) begin
      abc = 3'(v);
      b1.start  = 1'b1;
      b1.op_a   = abc[2];
      b1.op_b   = abc[1];
      b1.cin_in = abc[0];
      q1.push_back('{sum: 9'(abc[2]) + 9'(abc[1]) + 9'(abc[0]), t: cyc + 3});
      @(negedge clk);
      b1.start = 1'b0;
      chk("w1_busy_run", b1.busy, 1);
      chk("w1_lanes_run", {b1.add_a, b1.add_b, b1.add_cin}, abc);
      @(negedge clk);
      chk("w1_busy_flush", b1.busy, 1);
      @(negedge clk);
      chk("w1_busy_done", b1.busy, 0);
      @(negedge clk);
    end

    for (int i = 0; i < 50 && (q8.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    chk("queues_drained", q8.size() + q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
